// File: rtl/game_state_ctrl.sv
// game_state_ctrl: title/play/pause/death/win/game-over sequencer for the platformer.
// Ports: frame_clk, Reset (async, active-high); keycode[15:0] (two HID bytes),
//   hazard_hit, goal_reached in; state[2:0], Win, Dead, freeze, man_reset,
//   lives[1:0], time_left[6:0] out. Everything advances once per frame_clk edge.
module game_state_ctrl #(
  parameter int LIVES_INIT        = 3,
  parameter int TIME_LIMIT_SEC    = 99,
  parameter int FRAMES_PER_SEC    = 60,
  parameter int DEATH_HOLD_FRAMES = 120
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic [15:0] keycode,
  input  logic        hazard_hit,
  input  logic        goal_reached,
  output logic [2:0]  state,
  output logic        Win,
  output logic        Dead,
  output logic        freeze,
  output logic        man_reset,
  output logic [1:0]  lives,
  output logic [6:0]  time_left
);

  typedef enum logic [2:0] {
    TITLE     = 3'd0,
    RESPAWN   = 3'd1,
    PLAY      = 3'd2,
    PAUSE     = 3'd3,
    DYING     = 3'd4,
    WIN       = 3'd5,
    GAME_OVER = 3'd6
  } state_t;

  localparam logic [1:0] LIVES_RELOAD = 2'(LIVES_INIT);
  localparam logic [6:0] TIME_RELOAD  = 7'(TIME_LIMIT_SEC);
  localparam logic [5:0] SUB_LAST     = 6'(FRAMES_PER_SEC - 1);
  localparam logic [7:0] HOLD_RELOAD  = 8'(DEATH_HOLD_FRAMES - 1);

  localparam logic [7:0] KEY_ENTER = 8'h28;
  localparam logic [7:0] KEY_ESC   = 8'h29;

  state_t     cur;
  state_t     nxt;
  logic [7:0] hold_cnt;
  logic [5:0] sub_cnt;
  logic       enter_prev;
  logic       esc_prev;
  // Stays low for the first edge after reset so a key held through reset
  // (enter_prev cleared to 0) cannot masquerade as a fresh press.
  logic       key_armed;

  logic enter_dn;
  logic esc_dn;
  logic enter_press;
  logic esc_press;

  assign enter_dn    = (keycode[7:0] == KEY_ENTER) || (keycode[15:8] == KEY_ENTER);
  assign esc_dn      = (keycode[7:0] == KEY_ESC)   || (keycode[15:8] == KEY_ESC);
  assign enter_press = enter_dn && !enter_prev && key_armed;
  assign esc_press   = esc_dn   && !esc_prev   && key_armed;

  assign state = cur;

  always_comb begin
    nxt = cur;
    case (cur)
      TITLE:   if (enter_press) nxt = RESPAWN;
      RESPAWN: nxt = PLAY;
      PLAY: begin
        // Goal outranks hazard/time-out, which outrank pause.
        if (goal_reached)                           nxt = WIN;
        else if (hazard_hit || (time_left == 7'd0)) nxt = DYING;
        else if (esc_press)                         nxt = PAUSE;
      end
      PAUSE:   if (esc_press) nxt = PLAY;
      DYING:   if (hold_cnt == 8'd0) nxt = (lives == 2'd0) ? GAME_OVER : RESPAWN;
      WIN, GAME_OVER: if (enter_press) nxt = TITLE;
      default: nxt = TITLE;
    endcase
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      cur        <= TITLE;
      Win        <= 1'b0;
      Dead       <= 1'b0;
      freeze     <= 1'b1;
      man_reset  <= 1'b0;
      lives      <= LIVES_RELOAD;
      time_left  <= TIME_RELOAD;
      hold_cnt   <= 8'd0;
      sub_cnt    <= 6'd0;
      enter_prev <= 1'b0;
      esc_prev   <= 1'b0;
      key_armed  <= 1'b0;
    end else begin
      cur        <= nxt;
      enter_prev <= enter_dn;
      esc_prev   <= esc_dn;
      key_armed  <= 1'b1;

      // Outputs are registered from the next state so they match the state register.
      Win       <= (nxt == WIN);
      Dead      <= (nxt == DYING) || (nxt == GAME_OVER);
      freeze    <= (nxt == TITLE) || (nxt == PAUSE);
      man_reset <= (nxt == RESPAWN);

      // Level timer runs only while playing.
      if (cur == PLAY) begin
        if (sub_cnt == SUB_LAST) begin
          sub_cnt <= 6'd0;
          if (time_left != 7'd0) time_left <= time_left - 7'd1;
        end else begin
          sub_cnt <= sub_cnt + 6'd1;
        end
      end

      if ((nxt == RESPAWN) && (cur != RESPAWN)) sub_cnt <= 6'd0;

      if (cur == RESPAWN) begin
        time_left <= TIME_RELOAD;
        sub_cnt   <= 6'd0;
      end

      if ((nxt == DYING) && (cur != DYING)) begin
        if (lives != 2'd0) lives <= lives - 2'd1;
        hold_cnt <= HOLD_RELOAD;
      end else if ((cur == DYING) && (hold_cnt != 8'd0)) begin
        hold_cnt <= hold_cnt - 8'd1;
      end

      if (((cur == WIN) || (cur == GAME_OVER)) && (nxt == TITLE)) begin
        lives     <= LIVES_RELOAD;
        time_left <= TIME_RELOAD;
      end
    end
  end

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed bench for game_state_ctrl: default-parameter instance for the main flow,
// plus a small-parameter instance (2 s, 4 frames/s, 3-frame death hold) for timer expiry.
module tb_game_state_ctrl;

  logic        frame_clk = 1'b0;
  logic        Reset;
  logic [15:0] keycode;
  logic        hazard_hit;
  logic        goal_reached;
  logic [2:0]  state;
  logic        Win, Dead, freeze, man_reset;
  logic [1:0]  lives;
  logic [6:0]  time_left;

  logic [15:0] keycode2;
  logic        hazard2, goal2;
  logic [2:0]  state2;
  logic        win2, dead2, freeze2, man_reset2;
  logic [1:0]  lives2;
  logic [6:0]  time_left2;

  int vectors = 0;
  int miscompares = 0;

  always #5 frame_clk = ~frame_clk;

  game_state_ctrl dut (
    .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode),
    .hazard_hit(hazard_hit), .goal_reached(goal_reached),
    .state(state), .Win(Win), .Dead(Dead), .freeze(freeze),
    .man_reset(man_reset), .lives(lives), .time_left(time_left)
  );

  game_state_ctrl #(
    .LIVES_INIT(3), .TIME_LIMIT_SEC(2), .FRAMES_PER_SEC(4), .DEATH_HOLD_FRAMES(3)
  ) dut2 (
    .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode2),
    .hazard_hit(hazard2), .goal_reached(goal2),
    .state(state2), .Win(win2), .Dead(dead2), .freeze(freeze2),
    .man_reset(man_reset2), .lives(lives2), .time_left(time_left2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
      else begin
        miscompares++;
        $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
  endtask

  // One frame: inputs set beforehand are sampled at the edge, outputs read 1 time unit later.
  task automatic step();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".state"},     32'(state),     32'd0);
    chk({tag, ".freeze"},    32'(freeze),    32'd1);
    chk({tag, ".Win"},       32'(Win),       32'd0);
    chk({tag, ".Dead"},      32'(Dead),      32'd0);
    chk({tag, ".man_reset"}, 32'(man_reset), 32'd0);
    chk({tag, ".lives"},     32'(lives),     32'd3);
    chk({tag, ".time_left"}, 32'(time_left), 32'd99);
  endtask

  initial begin
    Reset = 1'b1;
    keycode = 16'h0; hazard_hit = 1'b0; goal_reached = 1'b0;
    keycode2 = 16'h0; hazard2 = 1'b0; goal2 = 1'b0;
    #3;
    chk_reset_vals("reset");
    chk("reset.dut2_time", 32'(time_left2), 32'd2);
    step(); step();
    #1 Reset = 1'b0;
    step();  // idle edge after reset

    // ---- Timer expiry on the small instance ----
    keycode2 = 16'h2800;  // Enter in the high byte
    step();
    chk("t2.respawn", 32'(state2), 32'd1);
    chk("t2.man_reset", 32'(man_reset2), 32'd1);
    keycode2 = 16'h0;
    step();
    chk("t2.play", 32'(state2), 32'd2);
    chk("t2.time_entry", 32'(time_left2), 32'd2);
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i == 3) chk("t2.time_f3", 32'(time_left2), 32'd2);
      if (i == 4) chk("t2.time_f4", 32'(time_left2), 32'd1);
      if (i == 7) chk("t2.time_f7", 32'(time_left2), 32'd1);
      if (i == 8) begin
        chk("t2.time_f8", 32'(time_left2), 32'd0);
        chk("t2.still_play_f8", 32'(state2), 32'd2);
      end
    end
    step();
    chk("t2.dying_f9", 32'(state2), 32'd4);
    chk("t2.lives_f9", 32'(lives2), 32'd2);
    chk("t2.dead_f9", 32'(dead2), 32'd1);
    step(); step();
    chk("t2.dying_last", 32'(state2), 32'd4);
    step();
    chk("t2.respawn_after_hold", 32'(state2), 32'd1);

    // ---- Basic flow: Enter held 5 frames ----
    chk("basic.title_idle", 32'(state), 32'd0);
    keycode = 16'h0028;
    step();
    chk("basic.respawn", 32'(state), 32'd1);
    chk("basic.man_reset", 32'(man_reset), 32'd1);
    step();
    chk("basic.play", 32'(state), 32'd2);
    chk("basic.man_reset_off", 32'(man_reset), 32'd0);
    chk("basic.freeze", 32'(freeze), 32'd0);
    chk("basic.time", 32'(time_left), 32'd99);
    step(); step(); step();
    chk("basic.single_press", 32'(state), 32'd2);

    // ---- Pause ----
    keycode = 16'h0029;
    step();
    chk("pause.enter", 32'(state), 32'd3);
    chk("pause.freeze", 32'(freeze), 32'd1);
    keycode = 16'h0;
    hazard_hit = 1'b1;
    repeat (200) step();
    chk("pause.hold_state", 32'(state), 32'd3);
    chk("pause.time_frozen", 32'(time_left), 32'd99);
    keycode = 16'h2900;
    step();
    chk("pause.resume", 32'(state), 32'd2);
    chk("pause.resume_freeze", 32'(freeze), 32'd0);
    keycode = 16'h0;

    // ---- Goal beats hazard ----
    goal_reached = 1'b1;
    step();
    chk("goal.win", 32'(state), 32'd5);
    chk("goal.Win", 32'(Win), 32'd1);
    chk("goal.Dead", 32'(Dead), 32'd0);
    chk("goal.lives", 32'(lives), 32'd3);
    goal_reached = 1'b0; hazard_hit = 1'b0;
    keycode = 16'h0028;
    step();
    chk("goal.to_title", 32'(state), 32'd0);
    keycode = 16'h0;
    step();

    // ---- Death sequence ----
    keycode = 16'h0028; step(); keycode = 16'h0; step();
    chk("death.play1", 32'(state), 32'd2);
    hazard_hit = 1'b1; step(); hazard_hit = 1'b0;
    chk("death.dying1", 32'(state), 32'd4);
    chk("death.lives1", 32'(lives), 32'd2);
    repeat (119) step();
    chk("death.hold_last", 32'(state), 32'd4);
    step();
    chk("death.respawn1", 32'(state), 32'd1);
    step();
    hazard_hit = 1'b1; step(); hazard_hit = 1'b0;
    chk("death.lives2", 32'(lives), 32'd1);
    repeat (120) step();
    chk("death.respawn2", 32'(state), 32'd1);
    step();
    hazard_hit = 1'b1; step(); hazard_hit = 1'b0;
    chk("death.lives3", 32'(lives), 32'd0);
    repeat (120) step();
    chk("death.game_over", 32'(state), 32'd6);
    repeat (5) step();
    chk("death.go_hold", 32'(state), 32'd6);
    chk("death.go_Dead", 32'(Dead), 32'd1);
    chk("death.go_lives", 32'(lives), 32'd0);
    keycode = 16'h0028; step();
    chk("death.to_title", 32'(state), 32'd0);
    chk("death.lives_reload", 32'(lives), 32'd3);
    keycode = 16'h0; step();

    // ---- Reset mid-death, key held through reset ----
    keycode = 16'h0028; step(); keycode = 16'h0; step();
    hazard_hit = 1'b1; step(); hazard_hit = 1'b0;
    chk("rst.dying", 32'(state), 32'd4);
    repeat (10) step();
    keycode = 16'h0028;
    Reset = 1'b1;
    #2;
    chk_reset_vals("rst.mid");
    #2 Reset = 1'b0;
    step(); step();
    chk("rst.held_key_ignored", 32'(state), 32'd0);
    keycode = 16'h0; step();
    keycode = 16'h2928;  // Enter and Escape together
    step();
    chk("rst.enter_esc_title", 32'(state), 32'd1);
    keycode = 16'h0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
